// File: rtl/uart_tx_if.sv
// Byte-level handshake between a UART transmitter and its client.
// The master supplies the byte and request; the slave reports status.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output tx_data, tx_start,
      input  tx_ready, tx_busy, tx_done
   );

   modport slave (
      input  tx_data, tx_start,
      output tx_ready, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// The bit-period divider restarts on every accept, so the start bit is never short.
module uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 1000000,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic      clk,
   input  logic      reset,
   uart_tx_if.slave  bus,
   output logic      tx
);
   localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
   localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic             par_bit;
   logic             ready;
   logic             done;
   logic             wrap;

   assign wrap         = (div == DIV_LAST);
   assign bus.tx_ready = ready;
   assign bus.tx_busy  = ~ready;
   assign bus.tx_done  = done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         div     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         ready   <= 1'b1;
         done    <= 1'b0;
         tx      <= 1'b1;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            div <= '0;
            tx  <= 1'b1;
            if (bus.tx_start) begin
               shift   <= bus.tx_data;
               // Parity is fixed at accept, since the shift register is consumed in flight.
               par_bit <= (^bus.tx_data) ^ (PARITY_ODD != 0);
               bit_cnt <= '0;
               tx      <= 1'b0;
               ready   <= 1'b0;
               state   <= START;
            end
         end else begin
            div <= wrap ? '0 : div + DIV_W'(1);
            if (wrap) begin
               case (state)
                  START: begin
                     tx    <= shift[0];
                     state <= DATA;
                  end
                  DATA: begin
                     if (bit_cnt == 3'd7) begin
                        if (PARITY_EN != 0) begin
                           tx    <= par_bit;
                           state <= PARITY;
                        end else begin
                           tx    <= 1'b1;
                           state <= STOP;
                        end
                     end else begin
                        tx      <= shift[1];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
                  PARITY: begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end
                  STOP: begin
                     state <= IDLE;
                     ready <= 1'b1;
                     done  <= 1'b1;
                  end
                  default: begin
                     tx    <= 1'b1;
                     ready <= 1'b1;
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end
endmodule
